// File: rtl/comma_aligner_10b.sv
// comma_aligner_10b: K28.5 comma hunt, 10-bit word alignment and lock for
// the 10b/8b receive path.
// Ports: clk, rst_n (async, active-low), ser_in/ser_en (serial bit + qualifier),
// word_out/word_valid (aligned group + strobe), is_comma, locked, align_err.
// Optional loss-of-sync logic: define COMMA_ALIGN_LOS_EN.
module comma_aligner_10b #(
   parameter logic [9:0]  COMMA_NEG   = 10'h17C,
   parameter logic [9:0]  COMMA_POS   = 10'h283,
   parameter int unsigned LOCK_CNT    = 3,
   parameter int unsigned LOS_BAD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ser_in,
   input  logic       ser_en,
   output logic [9:0] word_out,
   output logic       word_valid,
   output logic       is_comma,
   output logic       locked,
   output logic       align_err
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [2:0] LOCK_N = 3'(LOCK_CNT);
   localparam logic [3:0] LOS_N  = 4'(LOS_BAD_MAX);

   state_t     state_q, state_d;
   logic [9:0] sr_q, sr_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [2:0] good_cnt_q, good_cnt_d;
   logic [9:0] word_out_q, word_out_d;
   logic       word_valid_q, word_valid_d;
   logic       is_comma_q, is_comma_d;
   logic       locked_q, locked_d;
   logic       align_err_q, align_err_d;

`ifdef COMMA_ALIGN_LOS_EN
   logic [3:0] bad_cnt_q, bad_cnt_d;
   logic [3:0] bad_inc;
`else
   logic       unused_los_cfg;
   assign unused_los_cfg = ^LOS_N;
`endif

   logic [9:0] nsr;
   logic       hit;
   logic       bnd;
   logic [2:0] good_inc;

   always_comb begin
      nsr      = {ser_in, sr_q[9:1]};
      hit      = ser_en && ((nsr == COMMA_NEG) || (nsr == COMMA_POS));
      bnd      = ser_en && (bit_cnt_q == 4'd9);
      good_inc = good_cnt_q + 3'd1;

      state_d      = state_q;
      sr_d         = sr_q;
      bit_cnt_d    = bit_cnt_q;
      good_cnt_d   = good_cnt_q;
      word_out_d   = word_out_q;
      is_comma_d   = is_comma_q;
      locked_d     = locked_q;
      word_valid_d = 1'b0;
      align_err_d  = 1'b0;
`ifdef COMMA_ALIGN_LOS_EN
      bad_cnt_d    = bad_cnt_q;
      bad_inc      = bad_cnt_q + 4'd1;
`endif

      if (ser_en) begin
         sr_d      = nsr;
         bit_cnt_d = bnd ? 4'd0 : bit_cnt_q + 4'd1;
      end

      unique case (state_q)
         HUNT: begin
            if (hit) begin
               bit_cnt_d  = 4'd0;
               good_cnt_d = 3'd1;
               if (LOCK_N == 3'd1) begin
                  // Locking comma is emitted on the entry edge
                  state_d      = LOCKED;
                  locked_d     = 1'b1;
                  word_valid_d = 1'b1;
                  is_comma_d   = 1'b1;
                  word_out_d   = nsr;
               end else begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (hit && bnd) begin
               good_cnt_d = good_inc;
               // >= also covers re-entry from loss of sync when LOCK_CNT is 1
               if (good_inc >= LOCK_N) begin
                  state_d      = LOCKED;
                  locked_d     = 1'b1;
                  word_valid_d = 1'b1;
                  is_comma_d   = 1'b1;
                  word_out_d   = nsr;
               end
            end else if (hit) begin
               bit_cnt_d  = 4'd0;
               good_cnt_d = 3'd1;
            end
         end
         LOCKED: begin
            if (bnd) begin
               word_out_d   = nsr;
               word_valid_d = 1'b1;
               is_comma_d   = hit;
`ifdef COMMA_ALIGN_LOS_EN
               if (hit) bad_cnt_d = 4'd0;
`endif
            end else if (hit) begin
               align_err_d = 1'b1;
`ifdef COMMA_ALIGN_LOS_EN
               if (bad_inc >= LOS_N) begin
                  // Drop lock and treat this comma as a fresh hunt hit
                  locked_d   = 1'b0;
                  bad_cnt_d  = 4'd0;
                  bit_cnt_d  = 4'd0;
                  good_cnt_d = 3'd1;
                  state_d    = CHECK;
               end else begin
                  bad_cnt_d = bad_inc;
               end
`endif
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= HUNT;
         sr_q         <= '0;
         bit_cnt_q    <= '0;
         good_cnt_q   <= '0;
         word_out_q   <= '0;
         word_valid_q <= 1'b0;
         is_comma_q   <= 1'b0;
         locked_q     <= 1'b0;
         align_err_q  <= 1'b0;
`ifdef COMMA_ALIGN_LOS_EN
         bad_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         good_cnt_q   <= good_cnt_d;
         word_out_q   <= word_out_d;
         word_valid_q <= word_valid_d;
         is_comma_q   <= is_comma_d;
         locked_q     <= locked_d;
         align_err_q  <= align_err_d;
`ifdef COMMA_ALIGN_LOS_EN
         bad_cnt_q    <= bad_cnt_d;
`endif
      end
   end

   assign word_out   = word_out_q;
   assign word_valid = word_valid_q;
   assign is_comma   = is_comma_q;
   assign locked     = locked_q;
   assign align_err  = align_err_q;

endmodule

// File: tb/tb_comma_aligner_10b.sv
// tb_comma_aligner_10b: directed bench for comma_aligner_10b.
// Covers reset, acquisition, gapped data, CHECK realign and phase slip.
module tb_comma_aligner_10b;

   localparam logic [9:0] KN  = 10'h17C;
   localparam logic [9:0] KP  = 10'h283;
   localparam logic [9:0] D21 = 10'h155;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ser_in = 1'b0;
   logic       ser_en = 1'b0;
   logic [9:0] word_out;
   logic       word_valid;
   logic       is_comma;
   logic       locked;
   logic       align_err;

   int n_cmp = 0;
   int n_bad = 0;
   int vcnt  = 0;
   int ecnt  = 0;
   int v0;
   int e0;

   comma_aligner_10b dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ser_in     (ser_in),
      .ser_en     (ser_en),
      .word_out   (word_out),
      .word_valid (word_valid),
      .is_comma   (is_comma),
      .locked     (locked),
      .align_err  (align_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (word_valid) vcnt <= vcnt + 1;
      if (align_err)  ecnt <= ecnt + 1;
   end

   task automatic check_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      ser_in = b;
      ser_en = 1'b1;
      @(posedge clk);
      #1;
      ser_en = 1'b0;
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 0; i < 10; i++) send_bit(w[i]);
   endtask

   task automatic send_word_gaps(input logic [9:0] w);
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            ser_in = 1'($urandom_range(0, 1));
            idle(int'($urandom_range(1, 2)));
         end
         send_bit(w[i]);
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_word_out", 32'(word_out), 32'h0);
      check_eq("rst_word_valid", 32'(word_valid), 32'h0);
      check_eq("rst_is_comma", 32'(is_comma), 32'h0);
      check_eq("rst_locked", 32'(locked), 32'h0);
      check_eq("rst_align_err", 32'(align_err), 32'h0);
      rst_n = 1'b1;
      idle(2);

      // Acquisition: junk, then commas separated by D21.5
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_word(KN);
      check_eq("acq_c1_locked", 32'(locked), 32'h0);
      send_word(D21);
      send_word(KP);
      check_eq("acq_c2_locked", 32'(locked), 32'h0);
      send_word(D21);
      send_word(KN);
      check_eq("acq_no_early_valid", 32'(vcnt), 32'h0);
      check_eq("acq_c3_locked", 32'(locked), 32'h1);
      check_eq("acq_c3_valid", 32'(word_valid), 32'h1);
      check_eq("acq_c3_is_comma", 32'(is_comma), 32'h1);
      check_eq("acq_c3_word", 32'(word_out), 32'(KN));
      idle(1);
      check_eq("acq_valid_pulse", 32'(word_valid), 32'h0);

      // Locked data with ser_en gaps
      v0 = vcnt;
      for (int k = 0; k < 4; k++) begin
         send_word_gaps(D21);
         check_eq("gap_valid", 32'(word_valid), 32'h1);
         check_eq("gap_word", 32'(word_out), 32'(D21));
         check_eq("gap_is_comma", 32'(is_comma), 32'h0);
      end
      idle(1);
      check_eq("gap_valid_count", 32'(vcnt - v0), 32'd4);

      // Async reset mid-word while locked
      send_word(D21);
      for (int i = 0; i < 5; i++) send_bit(D21[i]);
      check_eq("pre_rst_locked", 32'(locked), 32'h1);
      check_eq("pre_rst_word", 32'(word_out), 32'(D21));
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_locked", 32'(locked), 32'h0);
      check_eq("arst_word_out", 32'(word_out), 32'h0);
      check_eq("arst_word_valid", 32'(word_valid), 32'h0);
      check_eq("arst_align_err", 32'(align_err), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Realign in CHECK: extra bit before the second comma
      v0 = vcnt;
      send_word(KN);
      check_eq("rl_hunt_locked", 32'(locked), 32'h0);
      send_word(D21);
      send_bit(1'b0);
      send_word(KP);
      check_eq("rl_c2_locked", 32'(locked), 32'h0);
      send_word(D21);
      send_word(KN);
      check_eq("rl_c3_locked", 32'(locked), 32'h0);
      send_word(D21);
      send_word(KP);
      check_eq("rl_no_early_valid", 32'(vcnt - v0), 32'd0);
      check_eq("rl_c4_locked", 32'(locked), 32'h1);
      check_eq("rl_c4_valid", 32'(word_valid), 32'h1);
      check_eq("rl_c4_is_comma", 32'(is_comma), 32'h1);
      check_eq("rl_c4_word", 32'(word_out), 32'(KP));

      // Slip: one extra bit while locked, then commas at the new phase
      send_word(D21);
      check_eq("slip_pre_word", 32'(word_out), 32'(D21));
      check_eq("slip_pre_valid", 32'(word_valid), 32'h1);
      e0 = ecnt;
      send_bit(1'b0);
`ifdef COMMA_ALIGN_LOS_EN
      for (int k = 0; k < 4; k++) begin
         send_word(KN);
         check_eq("los_align_err", 32'(align_err), 32'h1);
         check_eq("los_locked", 32'(locked), (k < 3) ? 32'h1 : 32'h0);
         send_word(D21);
      end
      send_word(KP);
      check_eq("los_relock_c1", 32'(locked), 32'h0);
      send_word(D21);
      send_word(KN);
      check_eq("los_relock_c2", 32'(locked), 32'h1);
      check_eq("los_relock_valid", 32'(word_valid), 32'h1);
      check_eq("los_relock_comma", 32'(is_comma), 32'h1);
      check_eq("los_relock_word", 32'(word_out), 32'(KN));
`else
      for (int k = 0; k < 4; k++) begin
         send_word(KN);
         check_eq("slip_align_err", 32'(align_err), 32'h1);
         check_eq("slip_locked", 32'(locked), 32'h1);
         check_eq("slip_valid", 32'(word_valid), 32'h0);
         check_eq("slip_old_phase", 32'(word_out), 32'h2F8);
         send_word(D21);
         check_eq("slip_data_phase", 32'(word_out), 32'h2AA);
      end
`endif
      idle(1);
      check_eq("slip_err_count", 32'(ecnt - e0), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
